// File: rtl/color_select_ctrl.sv
// Flood-It player-input front end: button sync/debounce, palette cursor, and the
// color-change / new-game request handshakes toward game_logic, plus move counting.
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | accepting presses; cursor moves here only
// SEL_REQ   | COLOR_SEL_SIG high, waiting for CHANGING_COLOR
// SEL_WAIT  | game_logic busy recoloring, waiting for CHANGING_COLOR low
// NEW_REQ   | START_NEW_GAME high, waiting for STARTED_GAME
// NEW_WAIT  | game_logic resetting the board, waiting for STARTED_GAME low
module color_select_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic       clock_i,
    input  logic       reset_i,
    input  logic       btn_left_i,
    input  logic       btn_right_i,
    input  logic       btn_select_i,
    input  logic       btn_new_i,
    input  logic [3:0] color_num_i,
    output logic [2:0] color_selected_o,
    output logic       color_sel_sig_o,
    input  logic       changing_color_i,
    output logic       start_new_game_o,
    input  logic       started_game_i,
    output logic [2:0] cursor_o,
    output logic [7:0] move_count_o,
    output logic       busy_o
);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SEL_REQ  = 3'd1,
        ST_SEL_WAIT = 3'd2,
        ST_NEW_REQ  = 3'd3,
        ST_NEW_WAIT = 3'd4
    } state_t;

    localparam logic [19:0] CNT_LAST = 20'(DEBOUNCE_CYCLES - 1);

    // Button vector order: {new, select, right, left}
    logic [3:0]       btn_raw;
    logic [3:0]       sync1_q, sync2_q;
    logic [3:0]       db_q, db_d, db_dly_q;
    logic [3:0]       press_q;
    logic [3:0][19:0] cnt_q, cnt_d;

    state_t     state_q, state_d;
    logic [2:0] cursor_q, cursor_d;
    logic [2:0] color_sel_q, color_sel_d;
    logic [7:0] move_q, move_d;

    logic [3:0] n_eff;
    logic [2:0] n_last;
    logic       cursor_oob;
    logic       press_left, press_right, press_sel, press_new;

    assign btn_raw     = {btn_new_i, btn_select_i, btn_right_i, btn_left_i};
    assign press_left  = press_q[0];
    assign press_right = press_q[1];
    assign press_sel   = press_q[2];
    assign press_new   = press_q[3];

    // Debounced level flips only after CNT_LAST+1 consecutive disagreeing samples.
    always_comb begin
        db_d  = db_q;
        cnt_d = cnt_q;
        for (int i = 0; i < 4; i++) begin
            if (sync2_q[i] == db_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
                db_d[i]  = sync2_q[i];
                cnt_d[i] = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + 20'd1;
            end
        end
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            db_q     <= '0;
            db_dly_q <= '0;
            press_q  <= '0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= btn_raw;
            sync2_q  <= sync1_q;
            db_q     <= db_d;
            db_dly_q <= db_q;
            press_q  <= db_q & ~db_dly_q;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        if (color_num_i == 4'd0) begin
            n_eff = 4'd1;
        end else if (color_num_i > 4'd8) begin
            n_eff = 4'd8;
        end else begin
            n_eff = color_num_i;
        end
        n_last     = 3'(n_eff - 4'd1);
        cursor_oob = ({1'b0, cursor_q} >= n_eff);
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= ST_IDLE;
            cursor_q    <= '0;
            color_sel_q <= '0;
            move_q      <= '0;
        end else begin
            state_q     <= state_d;
            cursor_q    <= cursor_d;
            color_sel_q <= color_sel_d;
            move_q      <= move_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cursor_d    = cursor_q;
        color_sel_d = color_sel_q;
        move_d      = move_q;
        case (state_q)
            ST_IDLE: begin
                if (press_new) begin
                    state_d = ST_NEW_REQ;
                end else if (press_sel) begin
                    color_sel_d = cursor_q;
                    state_d     = ST_SEL_REQ;
                end else if (press_left && !press_right) begin
                    cursor_d = (cursor_q == 3'd0 || cursor_oob) ? n_last : cursor_q - 3'd1;
                end else if (press_right && !press_left) begin
                    cursor_d = (cursor_oob || cursor_q == n_last) ? 3'd0 : cursor_q + 3'd1;
                end else if (!press_left && !press_right && cursor_oob) begin
                    cursor_d = 3'd0;
                end
            end
            ST_SEL_REQ: begin
                if (changing_color_i) begin
                    state_d = ST_SEL_WAIT;
                end
            end
            ST_SEL_WAIT: begin
                if (!changing_color_i) begin
                    move_d  = (move_q == 8'hFF) ? move_q : move_q + 8'd1;
                    state_d = ST_IDLE;
                end
            end
            ST_NEW_REQ: begin
                if (started_game_i) begin
                    state_d = ST_NEW_WAIT;
                end
            end
            ST_NEW_WAIT: begin
                if (!started_game_i) begin
                    move_d   = '0;
                    cursor_d = '0;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Requests are decoded from the registered state so reset drops them at once.
    always_comb begin
        busy_o           = (state_q != ST_IDLE);
        color_sel_sig_o  = (state_q == ST_SEL_REQ);
        start_new_game_o = (state_q == ST_NEW_REQ);
        color_selected_o = color_sel_q;
        cursor_o         = cursor_q;
        move_count_o     = move_q;
    end

endmodule

// File: tb/tb_color_select_ctrl.sv
// Self-checking bench for color_select_ctrl: cursor vector table, directed handshake
// corner cases, and randomized presses checked against a behavioural model.
module tb_color_select_ctrl;

    localparam int D = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       bl = 1'b0, br = 1'b0, bs = 1'b0, bn = 1'b0;
    logic [3:0] cnum = 4'd6;
    logic       chg = 1'b0, stg = 1'b0;
    logic [2:0] color_selected, cursor;
    logic       sel_sig, start_new, busy;
    logic [7:0] move_count;

    color_select_ctrl #(.DEBOUNCE_CYCLES(D)) dut (
        .clock_i          (clk),
        .reset_i          (rst),
        .btn_left_i       (bl),
        .btn_right_i      (br),
        .btn_select_i     (bs),
        .btn_new_i        (bn),
        .color_num_i      (cnum),
        .color_selected_o (color_selected),
        .color_sel_sig_o  (sel_sig),
        .changing_color_i (chg),
        .start_new_game_o (start_new),
        .started_game_i   (stg),
        .cursor_o         (cursor),
        .move_count_o     (move_count),
        .busy_o           (busy)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Behavioural model state
    int m_cursor = 0;
    int m_move   = 0;
    int m_n      = 6;
    int m_raw_n  = 6;

    typedef struct {
        int n;
        bit l;
        bit r;
        int exp;
    } vec_t;

    vec_t tbl[22];

    function automatic int neff(input int v);
        if (v == 0) return 1;
        if (v > 8) return 8;
        return v;
    endfunction

    function automatic int model_cursor(input int c, input bit l, input bit r, input int n);
        if (l && !r) return (c + n - 1) % n;
        if (r && !l) return (c + 1) % n;
        return c;
    endfunction

    function automatic int sat_inc(input int m);
        return (m >= 255) ? 255 : m + 1;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0d expected=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic set_n(input int v);
        cnum    = 4'(v);
        m_raw_n = v;
        m_n     = neff(v);
        if (m_cursor >= m_n) m_cursor = 0;
        tick();
        tick();
    endtask

    // Raw button high before edge 1; cursor must change right after edge D+4.
    task automatic press_lr(input bit l, input bit r, input int exp);
        int prev;
        prev = m_cursor;
        bl = l;
        br = r;
        repeat (D + 3) tick();
        chk("cursor_before_latency", int'(cursor), prev);
        tick();
        chk("cursor_after_latency", int'(cursor), exp);
        m_cursor = exp;
        repeat (2) tick();
        bl = 1'b0;
        br = 1'b0;
        repeat (10) tick();
    endtask

    // Caller raises the request button(s) at the current negedge. The bench plays
    // game_logic: ack ack_dly cycles after the request is seen, hold it ack_len cycles.
    // poke: 1 = RIGHT pressed during handshake, 2 = NEW pressed during handshake.
    task automatic handshake(input bit is_new, input int ack_dly, input int ack_len,
                             input int poke, input int exp_sel, input int exp_move,
                             input int exp_cursor, input bit chk_lat);
        int  lat;
        int  width;
        int  t_end;
        bit  seen;
        bit  req;
        bit  oth;
        lat   = 0;
        seen  = 1'b0;
        width = 0;
        t_end = ack_dly + ack_len;
        while (lat < 30 && !seen) begin
            tick();
            lat++;
            seen = is_new ? start_new : sel_sig;
        end
        bs = 1'b0;
        bn = 1'b0;
        if (!seen) begin
            chk("req_timeout", 0, 1);
            repeat (12) tick();
            return;
        end
        if (chk_lat) chk("req_latency", lat, D + 4);
        for (int t = 0; t <= t_end + 3; t++) begin
            if (t > 0) tick();
            req = is_new ? start_new : sel_sig;
            oth = is_new ? sel_sig : start_new;
            if (req) width++;
            chk("other_req_low", int'(oth), 0);
            if (!is_new) chk("color_selected_hold", int'(color_selected), exp_sel);
            if (t == t_end) begin
                chk("move_before", int'(move_count), m_move);
                chk("busy_during", int'(busy), 1);
            end
            if (t == t_end + 1) begin
                chk("move_after", int'(move_count), exp_move);
                chk("busy_after", int'(busy), 0);
                chk("cursor_after", int'(cursor), exp_cursor);
            end
            if (t == ack_dly) begin
                if (is_new) stg = 1'b1; else chg = 1'b1;
            end
            if (t == t_end) begin
                stg = 1'b0;
                chg = 1'b0;
            end
            if (t == 0 && poke == 1) br = 1'b1;
            if (t == 0 && poke == 2) bn = 1'b1;
            if (t == 10) begin
                br = 1'b0;
                bn = 1'b0;
            end
        end
        chk(is_new ? "new_req_width" : "sel_req_width", width, ack_dly + 1);
        m_move   = exp_move;
        m_cursor = exp_cursor;
        repeat (12) tick();
    endtask

    task automatic do_select(input int dly, input int len, input bit chk_lat);
        bs = 1'b1;
        handshake(1'b0, dly, len, 0, m_cursor, sat_inc(m_move), m_cursor, chk_lat);
    endtask

    task automatic do_new(input int dly, input int len, input bit chk_lat);
        bn = 1'b1;
        handshake(1'b1, dly, len, 0, 0, 0, 0, chk_lat);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit any;
        int op;

        tbl[0]  = '{6, 1'b0, 1'b1, 1};
        tbl[1]  = '{6, 1'b0, 1'b1, 2};
        tbl[2]  = '{6, 1'b0, 1'b1, 3};
        tbl[3]  = '{6, 1'b0, 1'b1, 4};
        tbl[4]  = '{6, 1'b0, 1'b1, 5};
        tbl[5]  = '{6, 1'b0, 1'b1, 0};
        tbl[6]  = '{6, 1'b0, 1'b1, 1};
        tbl[7]  = '{6, 1'b1, 1'b0, 0};
        tbl[8]  = '{6, 1'b1, 1'b0, 5};
        tbl[9]  = '{3, 1'b0, 1'b1, 1};
        tbl[10] = '{3, 1'b0, 1'b1, 2};
        tbl[11] = '{3, 1'b0, 1'b1, 0};
        tbl[12] = '{3, 1'b1, 1'b0, 2};
        tbl[13] = '{12, 1'b1, 1'b0, 1};
        tbl[14] = '{12, 1'b1, 1'b0, 0};
        tbl[15] = '{12, 1'b1, 1'b0, 7};
        tbl[16] = '{0, 1'b0, 1'b1, 0};
        tbl[17] = '{0, 1'b1, 1'b0, 0};
        tbl[18] = '{6, 1'b0, 1'b1, 1};
        tbl[19] = '{6, 1'b1, 1'b1, 1};
        tbl[20] = '{6, 1'b0, 1'b1, 2};
        tbl[21] = '{6, 1'b0, 1'b1, 3};

        // Reset state
        repeat (3) tick();
        chk("rst_color_selected", int'(color_selected), 0);
        chk("rst_sel_sig", int'(sel_sig), 0);
        chk("rst_start_new", int'(start_new), 0);
        chk("rst_cursor", int'(cursor), 0);
        chk("rst_move_count", int'(move_count), 0);
        chk("rst_busy", int'(busy), 0);
        rst = 1'b0;
        repeat (2) tick();

        // Cursor vector table
        foreach (tbl[i]) begin
            if (tbl[i].n != m_raw_n) set_n(tbl[i].n);
            press_lr(tbl[i].l, tbl[i].r, tbl[i].exp);
        end

        // Two-cycle glitch on SELECT must not register
        any = 1'b0;
        bs = 1'b1;
        tick();
        tick();
        bs = 1'b0;
        repeat (20) begin
            tick();
            if (sel_sig || busy) any = 1'b1;
        end
        chk("glitch_no_request", int'(any), 0);

        // Cursor=3 select, ack after 2, release 20 later, RIGHT pressed meanwhile
        bs = 1'b1;
        handshake(1'b0, 2, 20, 1, 3, 1, 3, 1'b1);

        // NEW and SELECT together: NEW wins, select is not queued
        bn = 1'b1;
        bs = 1'b1;
        handshake(1'b1, 1, 2, 0, 0, 0, 0, 1'b1);
        chk("no_late_select", int'(sel_sig), 0);

        // NEW pressed during a color change is discarded
        bs = 1'b1;
        handshake(1'b0, 3, 12, 2, m_cursor, sat_inc(m_move), m_cursor, 1'b1);

        // Acknowledge already high on request entry: one-cycle request
        do_select(0, 1, 1'b1);
        do_new(0, 1, 1'b1);

        // Randomized presses against the model
        for (int k = 0; k < 40; k++) begin
            op = int'($urandom_range(0, 9));
            case (op)
                0:       set_n(int'($urandom_range(0, 15)));
                1, 2, 3: press_lr(1'b1, 1'b0, model_cursor(m_cursor, 1'b1, 1'b0, m_n));
                4, 5, 6: press_lr(1'b0, 1'b1, model_cursor(m_cursor, 1'b0, 1'b1, m_n));
                7:       press_lr(1'b1, 1'b1, m_cursor);
                8:       do_select(int'($urandom_range(0, 4)), int'($urandom_range(1, 5)), 1'b1);
                default: begin
                    if ($urandom_range(0, 3) == 0)
                        do_new(int'($urandom_range(0, 4)), int'($urandom_range(1, 5)), 1'b1);
                    else
                        do_select(int'($urandom_range(0, 4)), int'($urandom_range(1, 5)), 1'b1);
                end
            endcase
        end

        // Saturate MOVE_COUNT, one extra move stays at 255, then a new game clears it
        while (m_move < 255) do_select(0, 1, 1'b0);
        chk("move_at_255", int'(move_count), 255);
        do_select(1, 2, 1'b1);
        chk("move_saturated", int'(move_count), 255);
        do_new(5, 3, 1'b1);
        chk("move_cleared", int'(move_count), 0);
        chk("cursor_cleared", int'(cursor), 0);

        // Reset while in SEL_REQ, SELECT held through reset release
        bs = 1'b1;
        any = 1'b0;
        for (int w = 0; w < 30 && !any; w++) begin
            tick();
            any = sel_sig;
        end
        chk("pre_reset_request", int'(any), 1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_sel_sig", int'(sel_sig), 0);
        chk("async_rst_busy", int'(busy), 0);
        tick();
        tick();
        rst = 1'b0;
        m_move   = 0;
        m_cursor = 0;
        tick();
        chk("post_rst_cursor", int'(cursor), 0);
        chk("post_rst_move", int'(move_count), 0);
        any = 1'b0;
        for (int w = 0; w < 30 && !any; w++) begin
            tick();
            any = sel_sig;
        end
        chk("held_btn_one_press", int'(any), 1);
        chk("held_btn_color", int'(color_selected), 0);
        chg = 1'b1;
        tick();
        tick();
        chg = 1'b0;
        repeat (3) tick();
        chk("held_btn_busy", int'(busy), 0);
        chk("held_btn_move", int'(move_count), 1);
        any = 1'b0;
        repeat (20) begin
            tick();
            if (sel_sig) any = 1'b1;
        end
        chk("held_btn_no_second", int'(any), 0);
        bs = 1'b0;
        repeat (10) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/color_select_ctrl.md
# color_select_ctrl

Player-input front end for the Flood-It board. It debounces the four raw push-buttons, moves a palette cursor, and initiates the two requests that `game_logic` responds to. The color-change request is the COLOR_SEL_SIG/CHANGING_COLOR handshake; the new-game request is the START_NEW_GAME/STARTED_GAME handshake. It also keeps the player's move count. It sits between the board-level button pins and `game_logic`, in the same clock domain as `game_logic`.

## Interface
- DEBOUNCE_CYCLES, 500000: consecutive stable synchronized samples required to accept a button level change; legal range 1..1048575 (20-bit counters).
- CLOCK  in  1  system clock, same domain as `game_logic` CLOCK.
- RESET  in  1  asynchronous, active-high; clears all state.
- BTN_LEFT, BTN_RIGHT, BTN_SELECT, BTN_NEW  in  1 each  raw asynchronous buttons, active-high.
- COLOR_NUM  in  4  palette size; 0 treated as 1, values above 8 treated as 8 (effective N).
- COLOR_SELECTED  out  3  color requested; stable from request until the handshake completes.
- COLOR_SEL_SIG  out  1  color-change request to `game_logic`.
- CHANGING_COLOR  in  1  `game_logic` busy/acknowledge for a color change.
- START_NEW_GAME  out  1  new-game request to `game_logic`.
- STARTED_GAME  in  1  `game_logic` acknowledge for a new game.
- CURSOR  out  3  currently highlighted palette index, 0..N-1.
- MOVE_COUNT  out  8  completed color changes since the last new game; saturates at 255.
- BUSY  out  1  high whenever the FSM is not in IDLE.

## Operation
- Each button passes through a 2-flop synchronizer and then a debouncer. The debounced level flips once the synchronized input has differed from it for DEBOUNCE_CYCLES consecutive cycles. Any agreeing sample clears the counter.
- A debounced rising edge produces a registered one-cycle press pulse. Falling edges produce nothing.
- FSM states: IDLE, SEL_REQ, SEL_WAIT, NEW_REQ, NEW_WAIT.
- **IDLE**, press priority NEW > SELECT > LEFT/RIGHT:
  - NEW: START_NEW_GAME<=1, go to NEW_REQ.
  - SELECT: COLOR_SELECTED<=CURSOR, COLOR_SEL_SIG<=1, go to SEL_REQ.
  - LEFT alone: CURSOR<=(CURSOR==0)?N-1:CURSOR-1.
  - RIGHT alone: CURSOR<=(CURSOR==N-1)?0:CURSOR+1.
  - LEFT and RIGHT in the same cycle: no change.
  - If CURSOR>=N (COLOR_NUM shrank) and no press is pending, CURSOR<=0.
- **SEL_REQ**: hold COLOR_SEL_SIG high until CHANGING_COLOR==1 is sampled. On that cycle COLOR_SEL_SIG<=0 and go to SEL_WAIT.
- **SEL_WAIT**: on CHANGING_COLOR==0, MOVE_COUNT<=min(MOVE_COUNT+1,255) and go to IDLE.
- **NEW_REQ**: hold START_NEW_GAME high until STARTED_GAME==1 is sampled. Then START_NEW_GAME<=0 and go to NEW_WAIT.
- **NEW_WAIT**: on STARTED_GAME==0, MOVE_COUNT<=0, CURSOR<=0, go to IDLE.
- Presses arriving outside IDLE are discarded, not queued. That includes NEW during a color change.
- There is no timeout: a request stays asserted until it is acknowledged.
- At most one of COLOR_SEL_SIG and START_NEW_GAME is high at any time.

## Timing
- Reset values:
  - Outputs: COLOR_SELECTED=0, COLOR_SEL_SIG=0, START_NEW_GAME=0, CURSOR=0, MOVE_COUNT=0, BUSY=0.
  - Internal: FSM=IDLE, synchronizers, debounced levels and counters all 0.
- A button held through reset release yields exactly one press, after debounce.
- Press latency: count the first rising CLOCK edge at which a raw button is high as edge 1, with the button held stable.
  - The press pulse is high after edge D+3, where D = DEBOUNCE_CYCLES.
  - The resulting output (COLOR_SEL_SIG, START_NEW_GAME or CURSOR) changes after edge D+4.
- Acknowledge response: one cycle.
  - COLOR_SEL_SIG drops on the edge after CHANGING_COLOR is first sampled high.
  - START_NEW_GAME drops on the edge after STARTED_GAME is first sampled high.
- Acknowledge already high on request entry: if CHANGING_COLOR (or STARTED_GAME) is already high on the cycle SEL_REQ (or NEW_REQ) is entered, the FSM advances on that cycle. Request width is then one cycle.
- MOVE_COUNT updates on the edge that leaves SEL_WAIT. A same-color request (`game_logic` finishes immediately) still counts as a move.
- BUSY is decoded from the registered state, with no combinational path from inputs.
- RESET asserted mid-handshake: outputs clear immediately. `game_logic` has no reset and treats the dropped request as abandoned.

## Test plan
- D=4, N=6, pulse RIGHT 7 times (each held 10 cycles, released 10 cycles) -> CURSOR goes 1,2,3,4,5,0,1. Each change occurs 8 cycles after the raw rise.
- D=4, 2-cycle glitch on BTN_SELECT -> no press. COLOR_SEL_SIG stays 0, BUSY stays 0.
- CURSOR=3, SELECT; bench model raises CHANGING_COLOR 2 cycles after COLOR_SEL_SIG and lowers it 20 cycles later ->
  - COLOR_SEL_SIG high 3 cycles, then low.
  - COLOR_SELECTED=3 throughout.
  - MOVE_COUNT 0->1 one cycle after CHANGING_COLOR falls.
  - RIGHT presses during the handshake leave CURSOR at 3.
- MOVE_COUNT=255, complete another selection -> MOVE_COUNT stays 255. Then NEW with STARTED_GAME acknowledged after 5 cycles and released after 3 more -> START_NEW_GAME high 6 cycles, then MOVE_COUNT=0 and CURSOR=0.
- NEW and SELECT press pulses in the same cycle -> START_NEW_GAME=1, COLOR_SEL_SIG=0. LEFT and RIGHT together -> CURSOR unchanged.
- Assert RESET while in SEL_REQ -> COLOR_SEL_SIG=0 and BUSY=0 immediately, without waiting for a clock edge. After reset release, CURSOR=0 and MOVE_COUNT=0.
